// File: rtl/param_cache.sv
`default_nettype none
// ============================================================================
// Module   : param_cache
// Purpose  : Two-way set-associative, write-through, no-write-allocate cache
//            with FIFO replacement, sitting between a 16-bit CPU and a
//            64-bit block memory. Stalls the CPU via `ready` during memory
//            transactions and keeps saturating read hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module param_cache #(
    parameter int IDX_BITS    = 2,
    parameter int MEM_LATENCY = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] address,
    input  logic [15:0] inputData,
    input  logic        read,
    input  logic        write,
    output logic [15:0] readData,
    output logic        ready,
    output logic        readM,
    output logic        writeM,
    output logic [15:0] addressM,
    inout  wire  [63:0] dataM,
    output logic [15:0] hitCount,
    output logic [15:0] missCount
);

    localparam int SETS     = 1 << IDX_BITS;
    localparam int TAG_BITS = 14 - IDX_BITS;
    localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MEM_RD = 2'd1,
        S_MEM_WR = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_done;
    logic [CNT_W-1:0]    r_count;
    logic                r_read_m;
    logic                r_write_m;
    logic [15:0]         r_address_m;
    logic [15:0]         r_hit_count;
    logic [15:0]         r_miss_count;

    logic [1:0]          r_valid  [SETS];
    logic [SETS-1:0]     r_victim;
    logic [TAG_BITS-1:0] r_tag    [SETS][2];
    logic [63:0]         r_data   [SETS][2];

    logic [IDX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0] w_tag;
    logic [1:0]          w_offset;
    logic                w_hit0;
    logic                w_hit1;
    logic                w_hit;
    logic                w_hit_way;
    logic                w_fill_way;
    logic [63:0]         w_line;
    logic                w_start_rd;
    logic                w_start_wr;
    logic                w_finish;
    logic                w_hit_inc;
    logic                w_write_hit;

    assign w_index  = address[IDX_BITS+1:2];
    assign w_tag    = address[15:IDX_BITS+2];
    assign w_offset = address[1:0];

    assign w_hit0    = r_valid[w_index][0] && (r_tag[w_index][0] == w_tag);
    assign w_hit1    = r_valid[w_index][1] && (r_tag[w_index][1] == w_tag);
    assign w_hit     = w_hit0 || w_hit1;
    assign w_hit_way = w_hit0 ? 1'b0 : 1'b1;

    // Fill goes to the first empty way, otherwise to the oldest (victim bit).
    assign w_fill_way = !r_valid[w_index][0] ? 1'b0 :
                        !r_valid[w_index][1] ? 1'b1 : r_victim[w_index];

    assign w_line   = r_data[w_index][w_hit_way];
    assign readData = w_line[{w_offset, 4'b0000} +: 16];

    assign readM     = r_read_m;
    assign writeM    = r_write_m;
    assign addressM  = r_address_m;
    assign hitCount  = r_hit_count;
    assign missCount = r_miss_count;

    // Memory bus is only driven while a write-through is in flight.
    assign dataM = r_write_m ? {{48{1'bz}}, inputData} : {64{1'bz}};

    // Next-state and request decode; done=1 acknowledges the held request.
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        w_start_rd   = 1'b0;
        w_start_wr   = 1'b0;
        w_finish     = 1'b0;
        w_hit_inc    = 1'b0;
        w_write_hit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_done) begin
                    ready = 1'b1;
                end else if (write) begin
                    w_start_wr   = 1'b1;
                    w_write_hit  = w_hit;
                    w_state_next = S_MEM_WR;
                end else if (read) begin
                    if (w_hit) begin
                        ready     = 1'b1;
                        w_hit_inc = 1'b1;
                    end else begin
                        w_start_rd   = 1'b1;
                        w_state_next = S_MEM_RD;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            S_MEM_RD, S_MEM_WR: begin
                if (r_count == '0) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Control state, memory strobes, counters and line status bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_done       <= 1'b0;
            r_count      <= '0;
            r_read_m     <= 1'b0;
            r_write_m    <= 1'b0;
            r_address_m  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_victim     <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= 2'b00;
            end
        end else begin
            r_state <= w_state_next;
            r_done  <= w_finish;
            if (w_start_rd) begin
                r_address_m <= {address[15:2], 2'b00};
                r_read_m    <= 1'b1;
                r_count     <= c_cnt_load;
                if (r_miss_count != 16'hFFFF) begin
                    r_miss_count <= r_miss_count + 16'd1;
                end
            end else if (w_start_wr) begin
                r_address_m <= address;
                r_write_m   <= 1'b1;
                r_count     <= c_cnt_load;
            end else if (w_finish) begin
                r_read_m  <= 1'b0;
                r_write_m <= 1'b0;
            end else if (r_state != S_IDLE) begin
                r_count <= r_count - 1'b1;
            end
            if (w_hit_inc && (r_hit_count != 16'hFFFF)) begin
                r_hit_count <= r_hit_count + 16'd1;
            end
            if (w_finish && (r_state == S_MEM_RD)) begin
                r_valid[w_index][w_fill_way] <= 1'b1;
                r_victim[w_index]            <= ~w_fill_way;
            end
        end
    end

    // Tag/data arrays: block fill on refill completion, word update on write hit.
    always_ff @(posedge clk) begin
        if (reset_n && w_finish && (r_state == S_MEM_RD)) begin
            r_tag[w_index][w_fill_way]  <= w_tag;
            r_data[w_index][w_fill_way] <= dataM;
        end else if (reset_n && w_write_hit) begin
            r_data[w_index][w_hit_way][{w_offset, 4'b0000} +: 16] <= inputData;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_cache
// Purpose  : Directed self-checking bench for param_cache (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_cache;

    localparam int c_lat = 6;

    logic        clk;
    logic        reset_n;
    logic [15:0] address;
    logic [15:0] inputData;
    logic        read;
    logic        write;
    logic [15:0] readData;
    logic        ready;
    logic        readM;
    logic        writeM;
    logic [15:0] addressM;
    wire  [63:0] dataM;
    logic [15:0] hitCount;
    logic [15:0] missCount;
    logic [63:0] mem_val;

    int checks;
    int fails;

    param_cache #(
        .IDX_BITS    (2),
        .MEM_LATENCY (c_lat)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .inputData (inputData),
        .read      (read),
        .write     (write),
        .readData  (readData),
        .ready     (ready),
        .readM     (readM),
        .writeM    (writeM),
        .addressM  (addressM),
        .dataM     (dataM),
        .hitCount  (hitCount),
        .missCount (missCount)
    );

    // Memory model: returns the staged block while a block read is requested.
    assign dataM = readM ? mem_val : {64{1'bz}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full memory transaction (read miss or write), CPU held until ready.
    task automatic mem_txn(input string tag, input logic [15:0] addr, input logic is_wr,
                           input logic [15:0] wdata, input logic [15:0] exp_addr_m,
                           input logic [15:0] exp_rdata);
        int n;
        logic strobe;
        @(posedge clk); #1;
        address   = addr;
        inputData = wdata;
        if (is_wr) write = 1'b1; else read = 1'b1;
        #1;
        check({tag, "_stall"}, 64'(ready), 64'(1'b0));
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            strobe = is_wr ? writeM : readM;
            if (!strobe) break;
            n++;
            if (n == 1) begin
                check({tag, "_addrM"}, 64'(addressM), 64'(exp_addr_m));
                if (is_wr) check({tag, "_dataM"}, 64'(dataM[15:0]), 64'(wdata));
            end
        end
        check({tag, "_strobe_len"}, 64'(n), 64'(c_lat));
        check({tag, "_ready"}, 64'(ready), 64'(1'b1));
        if (!is_wr) check({tag, "_rdata"}, 64'(readData), 64'(exp_rdata));
        read  = 1'b0;
        write = 1'b0;
    endtask

    // Zero-latency read hit.
    task automatic hit_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        @(posedge clk); #1;
        address = addr;
        read    = 1'b1;
        #1;
        check({tag, "_ready"}, 64'(ready), 64'(1'b1));
        check({tag, "_rdata"}, 64'(readData), 64'(exp));
        @(posedge clk); #1;
        read = 1'b0;
        check({tag, "_noreadM"}, 64'(readM), 64'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        fails     = 0;
        reset_n   = 1'b0;
        address   = '0;
        inputData = '0;
        read      = 1'b0;
        write     = 1'b0;
        mem_val   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'(1'b1));
        check("rst_readM", 64'(readM), 64'(1'b0));
        check("rst_writeM", 64'(writeM), 64'(1'b0));
        check("rst_addrM", 64'(addressM), 64'(16'h0000));
        check("rst_hits", 64'(hitCount), 64'(16'd0));
        check("rst_misses", 64'(missCount), 64'(16'd0));
        @(negedge clk);
        reset_n = 1'b1;

        // Cold miss on 0x0010.
        mem_val = 64'h4444_3333_2222_1111;
        mem_txn("miss10", 16'h0010, 1'b0, 16'h0000, 16'h0010, 16'h1111);
        check("miss10_misses", 64'(missCount), 64'(16'd1));
        check("miss10_hits", 64'(hitCount), 64'(16'd0));

        // Hit on word 3 of the same line.
        hit_read("hit13", 16'h0013, 16'h4444);
        check("hit13_hits", 64'(hitCount), 64'(16'd1));

        // Write hit: memory write-through and cached word update.
        mem_txn("wr11", 16'h0011, 1'b1, 16'hBEEF, 16'h0011, 16'h0000);
        hit_read("hit11", 16'h0011, 16'hBEEF);
        check("hit11_hits", 64'(hitCount), 64'(16'd2));
        check("wr11_misses", 64'(missCount), 64'(16'd1));

        // FIFO replacement in set 0.
        mem_val = 64'h0053_0052_0051_0050;
        mem_txn("miss50", 16'h0050, 1'b0, 16'h0000, 16'h0050, 16'h0050);
        mem_val = 64'h0093_0092_0091_0090;
        mem_txn("miss92", 16'h0092, 1'b0, 16'h0000, 16'h0090, 16'h0092);
        mem_val = 64'h4444_3333_2222_1111;
        mem_txn("remiss10", 16'h0011, 1'b0, 16'h0000, 16'h0010, 16'h2222);
        hit_read("hit90", 16'h0090, 16'h0090);
        mem_val = 64'h0053_0052_0051_0050;
        mem_txn("remiss50", 16'h0051, 1'b0, 16'h0000, 16'h0050, 16'h0051);
        check("repl_misses", 64'(missCount), 64'(16'd5));
        check("repl_hits", 64'(hitCount), 64'(16'd3));

        // Write miss does not allocate.
        mem_txn("wrF00", 16'h0F00, 1'b1, 16'h1234, 16'h0F00, 16'h0000);
        mem_val = 64'hF003_F002_F001_F000;
        mem_txn("missF00", 16'h0F00, 1'b0, 16'h0000, 16'h0F00, 16'hF000);
        check("noalloc_misses", 64'(missCount), 64'(16'd6));

        // Reset in the third MEM_RD cycle aborts the refill.
        mem_val = 64'h0023_0022_0021_0020;
        @(posedge clk); #1;
        address = 16'h0020;
        read    = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("abort_readM_before", 64'(readM), 64'(1'b1));
        reset_n = 1'b0;
        #1;
        check("abort_readM", 64'(readM), 64'(1'b0));
        read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_hits", 64'(hitCount), 64'(16'd0));
        check("abort_misses", 64'(missCount), 64'(16'd0));
        mem_txn("abort_remiss", 16'h0020, 1'b0, 16'h0000, 16'h0020, 16'h0020);
        check("abort_remiss_count", 64'(missCount), 64'(16'd1));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_cache.md
# param_cache

Parametrised two-way set-associative, write-through, no-write-allocate instruction/data cache with FIFO replacement. It sits between the CPU datapath (16-bit words, 16-bit addresses) and the 64-bit block memory. It stalls the CPU through `ready` while a memory transaction is in flight. It adds configurable set count and memory latency, a registered memory address, and saturating read hit/miss counters.

## Interface
- `IDX_BITS`, default 2: index width; sets = 2^IDX_BITS; range 1..10.
- `MEM_LATENCY`, default 6: cycles `readM`/`writeM` stay high per memory transaction; minimum 1.
- `clk` in 1: single clock; all state changes on posedge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `address` in 16: CPU word address; held stable by the CPU while `ready`=0.
- `inputData` in 16: CPU write data.
- `read` in 1: CPU read request.
- `write` in 1: CPU write request; has priority if `read` is also high.
- `readData` out 16: selected word of the hit line; combinational; X/don't-care when there is no hit.
- `ready` out 1: request complete this cycle; 0 means the CPU must hold its request.
- `readM` out 1: memory block read strobe.
- `writeM` out 1: memory word write strobe.
- `addressM` out 16: registered memory address.
- `dataM` inout 64: memory bus. Driven with {48'bz, inputData} only while `writeM`=1; otherwise high-Z.
- `hitCount` out 16: saturating count of read hits.
- `missCount` out 16: saturating count of read misses.

## Operation
- Address split: offset = address[1:0] (word in block), index = address[IDX_BITS+1:2], tag = address[15:IDX_BITS+2].
- Per set and way: valid bit, tag, 64-bit block. Per set: one victim bit.
- Hit: way valid and tag equal. Way 0 wins if both ways hit, which is illegal and must never occur.
- `readData` = block[16*offset+15 : 16*offset] of the hit way.
- FSM states:
  - IDLE: evaluates requests.
  - MEM_RD: block fetch.
  - MEM_WR: write-through.
- Register `done` is set on the posedge that returns to IDLE and cleared on the next posedge.
- IDLE, read hit: `ready`=1 with no state change. `hitCount`+1 if `done`=0.
- IDLE, read miss, `done`=0:
  - `ready`=0.
  - Next edge: go to MEM_RD; `addressM` <= {address[15:2],2'b00}; `readM` <= 1; counter <= MEM_LATENCY-1; `missCount`+1.
- IDLE, write, `done`=0:
  - `ready`=0.
  - Next edge: go to MEM_WR; `addressM` <= address; `writeM` <= 1; counter <= MEM_LATENCY-1.
  - On a write hit, the addressed word in the hit way is updated on that same edge. Valid bit and victim bit are unchanged.
  - On a write miss, nothing is allocated.
- IDLE with `done`=1: `ready`=1 for the held request and no new transaction starts. The held read now hits after the refill; the held write is already written. The CPU must drop or change its request after this cycle.
- MEM_RD/MEM_WR: counter decrements each edge. On the edge where counter = 0:
  - `readM`/`writeM` go to 0; state goes to IDLE; `done` goes to 1.
  - MEM_RD only: dataM is sampled into the victim way. Valid <= 1, tag <= address tag, victim bit <= other way.
- Victim way selection: first invalid way (way 0 first); if both ways are valid, the way named by the victim bit. This is FIFO replacement: hits never touch the victim bit.
- Counters saturate at 16'hFFFF. Misses are counted once per miss; the refill re-hit is not counted.
- `read`=`write`=0 in IDLE: `ready`=1, idle.

## Timing
- Reset values (asynchronous): all valid=0, all victim bits=0, state IDLE, `done`=0, `readM`=`writeM`=0, `addressM`=0, counters=0.
  - Tag and data arrays need not be reset.
  - Reset asserted mid-transaction aborts it immediately, strobes drop, and no line is filled.
- Read hit latency: 0 cycles (combinational `ready`/`readData`).
- Read miss: the strobe is high for exactly MEM_LATENCY cycles. `ready` returns the cycle after the fill edge. Total stall = MEM_LATENCY+1 cycles.
- Write, hit or miss: same stall as a read miss.
- MEM_LATENCY=1: strobe high for one cycle; the fill occurs at the end of that cycle.
- Requests arriving while not IDLE are ignored. `address` must be stable throughout the transaction.

## Test plan
- Reset, then read 0x0010: `ready`=0; `readM` high 6 cycles with `addressM`=0x0010; mem returns 0x4444_3333_2222_1111. Then `ready`=1, `readData`=0x1111. Counts: miss=1, hit=0.
- Read 0x0013 after the previous scenario: 0-cycle hit, `readData`=0x4444, `hitCount`=1, no `readM`.
- Write 0x0011 with data 0xBEEF: `writeM` high 6 cycles, dataM[15:0]=0xBEEF, `addressM`=0x0011, upper bits Z. Then read 0x0011 hits with 0xBEEF.
- Replacement: fill tags at addresses 0x0010, then 0x0050 and 0x0090, all index 0 with IDX_BITS=2. 0x0090 evicts the 0x0010 line; a read of 0x0010 misses, 0x0050 misses (evicted by the 0x0010 refill), 0x0090 hits.
- Write miss to 0x0F00: memory write occurs; a subsequent read of 0x0F00 misses (no allocate).
- Assert `reset_n`=0 at the 3rd cycle of MEM_RD: `readM`=0 at once. After reset, reading the same address misses again and both counters read 0.
